mem_stage_wb: RTL
=================

MEM_STAGE_WB -- requirements
Module: mem_stage_wb

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum cycles a data-memory request may wait for dmem_ack_i before the timeout error fires.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 decoder_i  input  5  SHALL carry EX/MEM control bits: [4] RegWrite, [3] MemRead, [2] MemWrite, [1] MemtoReg, [0] Branch.
REQ-005 PC_plus4_i  input  32  SHALL be the PC+4 of the instruction in MEM.
REQ-006 zero_i  input  1  SHALL be the ALU zero flag.
REQ-007 FURslt_i  input  32  SHALL be the ALU result, also the memory address.
REQ-008 ReadData2_i  input  32  SHALL be the store data.
REQ-009 instruction_i  input  5  SHALL be the destination register number.
REQ-010 jump_addr_i / jump_i  input  32 / 1  SHALL be the resolved jump-or-branch target and the jump flag.
REQ-011 dmem_req_o, dmem_we_o  output  1 each  SHALL be the memory request and write enable.
REQ-012 dmem_addr_o, dmem_wdata_o  output  32 each  SHALL be the memory address and write data.
REQ-013 dmem_ack_i, dmem_rdata_i  input  1 / 32  SHALL be the memory acknowledge and read data (rdata valid with ack).
REQ-014 stall_o  output  1  SHALL hold IF/ID/EX and the EX/MEM register when high.
REQ-015 pc_src_o, pc_target_o, flush_o  output  1/32/1  SHALL be the PC redirect request, the redirect target and the flush of younger stages.
REQ-016 valid_o, RegWrite_o, MemtoReg_o  output  1 each  SHALL be the MEM/WB valid bit and write-back controls.
REQ-017 MemData_o, FURslt_o, PC_plus4_o  output  32 each  SHALL be the registered load data, ALU result and PC+4.
REQ-018 WriteReg_o  output  5  SHALL be the registered destination register.
REQ-019 err_o  output  1  SHALL be the sticky error flag (timeout or misalignment).

Function
REQ-020 The FSM SHALL have states IDLE and WAIT.
REQ-021 In IDLE with MemRead|MemWrite set and FURslt_i[1:0]==0, dmem_req_o SHALL assert combinationally, with dmem_we_o=MemWrite, dmem_addr_o=FURslt_i and dmem_wdata_o=ReadData2_i.
REQ-022 If dmem_ack_i is high in that same cycle, the access SHALL complete with zero stall; otherwise stall_o SHALL assert and the FSM SHALL move to WAIT.
REQ-023 In WAIT, req, we, addr and wdata SHALL stay stable (EX/MEM is held) and stall_o SHALL stay high until the cycle dmem_ack_i is high; the FSM then SHALL return to IDLE and stall_o SHALL drop combinationally in that ack cycle.
REQ-024 A 4-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; when it reaches TIMEOUT without ack, err_o SHALL set, the access SHALL be abandoned (a bubble is written) and the FSM SHALL go to IDLE.
REQ-025 A memory op with FURslt_i[1:0]!=0 SHALL issue no request, SHALL set err_o and SHALL write a bubble.
REQ-026 The MEM/WB register SHALL load on every non-stalled cycle with 1-cycle latency; on completion of a load, MemData_o SHALL take dmem_rdata_i from the ack cycle.
REQ-027 While stall_o is high, the MEM/WB register SHALL load a bubble: valid_o=0, RegWrite_o=0, other fields don't-care but held.
REQ-028 A redirect condition SHALL be defined as jump_i | (Branch & zero_i).
REQ-029 pc_src_o and flush_o SHALL assert combinationally for exactly the one non-stalled cycle in IDLE in which the redirect condition holds, and pc_target_o SHALL equal jump_addr_i in that cycle.
REQ-030 stall_o SHALL take priority over pc_src_o, which SHALL be suppressed while stalled.
REQ-031 A branch or jump SHALL never issue a memory request, even if Mem bits are set; this case SHALL be treated as an ALU op.

Reset
REQ-032 On rst_n low, the FSM SHALL go to IDLE and the counter to 0, all MEM/WB outputs and err_o SHALL clear to 0, and dmem_req_o, stall_o and pc_src_o SHALL be 0 immediately.
REQ-033 Reset asserted during WAIT SHALL abandon the access with no write-back; a late dmem_ack_i after reset SHALL be ignored in IDLE when no memory op is present.

Structure
REQ-034 Decoder bit indices, FSM state encodings and the TIMEOUT default SHALL live in the shared pipeline package.
REQ-035 The MEM/WB register SHALL be a sub-module named reg_MEM_WB; FSM, counter and redirect logic SHALL live in mem_stage_wb.

Verification
REQ-036 ALU op with RegWrite=1, FURslt_i=0x10 and WriteReg=5 -> next cycle valid_o=1, RegWrite_o=1, FURslt_o=0x10, WriteReg_o=5, stall_o never high.
REQ-037 Load from address 0x40 with ack after 3 cycles and rdata=0xDEADBEEF -> stall_o high for 3 cycles, then MemData_o=0xDEADBEEF with valid_o=1; bubbles are written during the stall.
REQ-038 Store to address 0x8 with wdata 0x1234 and same-cycle ack -> one dmem_req_o pulse with we=1, stall_o=0.
REQ-039 Branch=1, zero_i=1 and jump_addr_i=0x200 -> pc_src_o=flush_o=1 for one cycle with pc_target_o=0x200; with zero_i=0, no redirect.
REQ-040 Load with no ack -> err_o sets after 15 WAIT cycles, stall releases and a bubble is written; a load to address 0x41 -> no request and err_o=1.
REQ-041 rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously and the FSM in IDLE after release.

Source files
------------

// File: rtl/mem_stage_wb_pkg.sv
// Shared pipeline definitions for the memory stage.
//   - EX/MEM decoder bit positions
//   - memory-stage FSM state encoding
//   - default request timeout and wait-counter width
//   - alignment helper for word accesses
package mem_stage_wb_pkg;

  localparam int DEC_REGWRITE = 4;
  localparam int DEC_MEMREAD  = 3;
  localparam int DEC_MEMWRITE = 2;
  localparam int DEC_MEMTOREG = 1;
  localparam int DEC_BRANCH   = 0;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int          CNT_W           = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_wb_reg_mem_wb.sv
// MEM/WB pipeline register.
//   clk_i, rst_n       : clock, asynchronous active-low reset
//   stall_i            : memory stage is stalled; load a bubble, hold data
//   bubble_i           : instruction is abandoned; load fields but mark invalid
//   mem_load_i         : a load completes this cycle; capture mem_data_i
//   reg_write_i, memto_reg_i, mem_data_i, furslt_i, pc_plus4_i, write_reg_i
//                      : write-back fields from the memory stage
//   valid_o ... WriteReg_o : registered write-back fields
module reg_MEM_WB (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        bubble_i,
  input  logic        mem_load_i,
  input  logic        reg_write_i,
  input  logic        memto_reg_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] furslt_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [4:0]  write_reg_i,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] MemData_o,
  output logic [31:0] FURslt_o,
  output logic [31:0] PC_plus4_o,
  output logic [4:0]  WriteReg_o
);

  logic        valid_d, valid_q;
  logic        reg_write_d, reg_write_q;
  logic        memto_reg_d, memto_reg_q;
  logic [31:0] mem_data_d, mem_data_q;
  logic [31:0] furslt_d, furslt_q;
  logic [31:0] pc_plus4_d, pc_plus4_q;
  logic [4:0]  write_reg_d, write_reg_q;

  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    memto_reg_d = memto_reg_q;
    mem_data_d  = mem_data_q;
    furslt_d    = furslt_q;
    pc_plus4_d  = pc_plus4_q;
    write_reg_d = write_reg_q;
    if (!stall_i) begin
      // Abandoned instructions still flow their fields but never write back.
      valid_d     = !bubble_i;
      reg_write_d = reg_write_i && !bubble_i;
      memto_reg_d = memto_reg_i;
      furslt_d    = furslt_i;
      pc_plus4_d  = pc_plus4_i;
      write_reg_d = write_reg_i;
      if (mem_load_i) mem_data_d = mem_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      mem_data_q  <= '0;
      furslt_q    <= '0;
      pc_plus4_q  <= '0;
      write_reg_q <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      mem_data_q  <= mem_data_d;
      furslt_q    <= furslt_d;
      pc_plus4_q  <= pc_plus4_d;
      write_reg_q <= write_reg_d;
    end
  end

  assign valid_o    = valid_q;
  assign RegWrite_o = reg_write_q;
  assign MemtoReg_o = memto_reg_q;
  assign MemData_o  = mem_data_q;
  assign FURslt_o   = furslt_q;
  assign PC_plus4_o = pc_plus4_q;
  assign WriteReg_o = write_reg_q;

endmodule

// File: rtl/mem_stage_wb.sv
// Pipeline memory stage with MEM/WB register.
//   clk_i, rst_n                 : clock, asynchronous active-low reset
//   decoder_i                    : EX/MEM controls {RegWrite, MemRead, MemWrite, MemtoReg, Branch}
//   PC_plus4_i, zero_i, FURslt_i, ReadData2_i, instruction_i : EX/MEM data
//   jump_addr_i, jump_i          : resolved redirect target and jump flag
//   dmem_*                       : data-memory request/ack interface
//   stall_o                      : holds IF/ID/EX and EX/MEM
//   pc_src_o, pc_target_o, flush_o : PC redirect and younger-stage flush
//   valid_o ... WriteReg_o       : registered MEM/WB fields
//   err_o                        : sticky timeout / misalignment flag
//   state_dbg_o                  : current FSM state (0 = IDLE, 1 = WAIT)
//
// Memory handshake: dmem_req_o is held high with stable we/addr/wdata until
// the cycle dmem_ack_i is high; that cycle completes the access and
// dmem_rdata_i is valid in it. A request may complete in its first cycle.
module mem_stage_wb
  import mem_stage_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [4:0]  decoder_i,
  input  logic [31:0] PC_plus4_i,
  input  logic        zero_i,
  input  logic [31:0] FURslt_i,
  input  logic [31:0] ReadData2_i,
  input  logic [4:0]  instruction_i,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        pc_src_o,
  output logic [31:0] pc_target_o,
  output logic        flush_o,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] MemData_o,
  output logic [31:0] FURslt_o,
  output logic [31:0] PC_plus4_o,
  output logic [4:0]  WriteReg_o,
  output logic        err_o,
  output logic        state_dbg_o
);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;

  logic req, stall, bubble, load_done, redirect;
  logic mem_read, mem_write, is_ctrl, mem_op;

  assign mem_read  = decoder_i[DEC_MEMREAD];
  assign mem_write = decoder_i[DEC_MEMWRITE];
  // Branches and jumps are treated as ALU ops even if Mem bits are set.
  assign is_ctrl   = decoder_i[DEC_BRANCH] || jump_i;
  assign mem_op    = (mem_read || mem_write) && !is_ctrl;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req       = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    load_done = 1'b0;
    redirect  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (is_aligned(FURslt_i[1:0])) begin
            req = 1'b1;
            if (dmem_ack_i) begin
              load_done = mem_read;
            end else begin
              stall   = 1'b1;
              state_d = ST_WAIT;
              cnt_d   = '0;
            end
          end else begin
            err_d  = 1'b1;
            bubble = 1'b1;
          end
        end else begin
          redirect = jump_i || (decoder_i[DEC_BRANCH] && zero_i);
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem_ack_i) begin
          load_done = mem_read;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Give up: release the stall so the instruction leaves as a bubble.
          err_d   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Combinational outputs are gated by reset so they drop immediately.
  assign dmem_req_o   = rst_n && req;
  assign dmem_we_o    = rst_n && req && mem_write;
  assign dmem_addr_o  = FURslt_i;
  assign dmem_wdata_o = ReadData2_i;
  assign stall_o      = rst_n && stall;
  assign pc_src_o     = rst_n && redirect;
  assign flush_o      = rst_n && redirect;
  assign pc_target_o  = jump_addr_i;
  assign err_o        = err_q;
  assign state_dbg_o  = state_q;

  reg_MEM_WB u_reg_mem_wb (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .bubble_i    (bubble),
    .mem_load_i  (load_done),
    .reg_write_i (decoder_i[DEC_REGWRITE]),
    .memto_reg_i (decoder_i[DEC_MEMTOREG]),
    .mem_data_i  (dmem_rdata_i),
    .furslt_i    (FURslt_i),
    .pc_plus4_i  (PC_plus4_i),
    .write_reg_i (instruction_i),
    .valid_o     (valid_o),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .MemData_o   (MemData_o),
    .FURslt_o    (FURslt_o),
    .PC_plus4_o  (PC_plus4_o),
    .WriteReg_o  (WriteReg_o)
  );

endmodule
